// File: rtl/systolic_pkg.sv
// systolic_pkg: controller state encoding and array constants shared with systolic_array.
package systolic_pkg;
    localparam int N_DEF  = 4;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } ctrl_state_t;
endpackage

// File: rtl/valid_pipe.sv
// valid_pipe: enable-gated shift register that follows real vectors through the array latency.
module valid_pipe #(
    parameter int LAT = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic in_i,
    output logic top_o,
    output logic empty_o
);
    logic [LAT-1:0] vld_q, vld_d;

    always_comb vld_d = en_i ? {vld_q[LAT-2:0], in_i} : vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    assign top_o   = vld_q[LAT-1];
    assign empty_o = ~|vld_q;
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: loads a weight tile, streams activation vectors, drains the array and
// freezes the datapath whenever the result sink stalls.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int M_W = 8,
    parameter int LAT = 2*N-1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [M_W-1:0]       num_vec,
    output logic                 busy,
    output logic                 done,
    input  logic                 w_valid,
    output logic                 w_ready,
    output logic                 w_load,
    output logic [$clog2(N)-1:0] w_row,
    input  logic                 a_valid,
    output logic                 a_ready,
    output logic                 arr_en,
    output logic                 arr_in_valid,
    output logic                 res_valid,
    input  logic                 res_ready
);
    localparam int RW = $clog2(N);

    ctrl_state_t    state_q, state_d;
    logic [M_W-1:0] num_q, num_d, sent_q, sent_d;
    logic [RW-1:0]  row_q, row_d;
    logic           pipe_top, pipe_empty;

    valid_pipe #(.LAT(LAT)) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .en_i    (arr_en),
        .in_i    (arr_in_valid),
        .top_o   (pipe_top),
        .empty_o (pipe_empty)
    );

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        sent_d       = sent_q;
        row_d        = row_q;
        busy         = state_q != S_IDLE;
        done         = state_q == S_DONE;
        w_ready      = state_q == S_LOAD_W;
        w_load       = w_ready & w_valid;
        w_row        = row_q;
        a_ready      = (state_q == S_STREAM) & res_ready;
        arr_en       = ((state_q == S_STREAM) | (state_q == S_DRAIN)) & res_ready;
        arr_in_valid = a_ready & a_valid;
        // results only leave the array on cycles the sink actually takes them
        res_valid    = pipe_top & arr_en;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LOAD_W;
                num_d   = num_vec;
                sent_d  = '0;
                row_d   = '0;
            end
            S_LOAD_W: if (w_load) begin
                row_d = row_q + 1'b1;
                if (row_q == RW'(N-1)) state_d = (num_q == '0) ? S_DRAIN : S_STREAM;
            end
            S_STREAM: if (arr_in_valid) begin
                sent_d = sent_q + 1'b1;
                if (sent_d == num_q) state_d = S_DRAIN;
            end
            S_DRAIN: if (pipe_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            sent_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            sent_q  <= sent_d;
            row_q   <= row_d;
        end
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed per-cycle checks of the systolic_ctrl sequencer.
module tb_systolic_ctrl;
    logic       clk, rst, start, w_valid, a_valid, res_ready;
    logic [7:0] num_vec;
    logic       busy, done, w_ready, w_load, a_ready, arr_en, arr_in_valid, res_valid;
    logic [1:0] w_row;
    logic [7:0] obs, exp_v;
    int         n_chk, n_fail;

    systolic_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_load(w_load), .w_row(w_row),
        .a_valid(a_valid), .a_ready(a_ready), .arr_en(arr_en), .arr_in_valid(arr_in_valid),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    assign obs = {busy, done, w_ready, w_load, a_ready, arr_en, arr_in_valid, res_valid};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic in_rng(input int t, input int lo, input int hi);
        return t >= lo && t <= hi;
    endfunction

    task automatic test_reset();
        rst = 1; start = 0; num_vec = 0; w_valid = 1; a_valid = 1; res_ready = 1;
        #2;
        n_chk++;
        if (obs !== 8'h00 || w_row !== 2'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b row %0d, want 00000000 row 0", obs, w_row);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    // start held for several cycles and num_vec changed after acceptance must not matter
    task automatic test_basic();
        for (int t = 0; t <= 18; t++) begin
            start = t <= 3; num_vec = (t == 0) ? 8'd3 : 8'd7;
            w_valid = 1; a_valid = 1; res_ready = 1;
            @(negedge clk);
            exp_v = {in_rng(t,1,16), t == 16, in_rng(t,1,4), in_rng(t,1,4),
                     in_rng(t,5,7), in_rng(t,5,15), in_rng(t,5,7), in_rng(t,12,14)};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL basic t=%0d: got %b want %b", t, obs, exp_v);
            end
            if (in_rng(t,1,4)) begin
                n_chk++;
                if (w_row !== 2'(t-1)) begin
                    n_fail++;
                    $display("FAIL basic w_row t=%0d: got %0d want %0d", t, w_row, t-1);
                end
            end
            @(posedge clk); #1;
        end
        start = 0;
    endtask

    task automatic test_weight_stall();
        logic [1:0] rows [0:6];
        rows = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
        for (int t = 0; t <= 17; t++) begin
            start = t == 0; num_vec = 8'd1;
            w_valid = (t == 1) || (t == 2) || (t == 5) || (t == 6);
            a_valid = 1; res_ready = 1;
            @(negedge clk);
            exp_v = {in_rng(t,1,16), t == 16, in_rng(t,1,6), w_valid && in_rng(t,1,6),
                     t == 7, in_rng(t,7,15), t == 7, t == 14};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL wstall t=%0d: got %b want %b", t, obs, exp_v);
            end
            if (in_rng(t,1,6)) begin
                n_chk++;
                if (w_row !== rows[t]) begin
                    n_fail++;
                    $display("FAIL wstall w_row t=%0d: got %0d want %0d", t, w_row, rows[t]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bubbles();
        int n_in = 0;
        for (int t = 0; t <= 21; t++) begin
            start = t == 0; num_vec = 8'd4;
            w_valid = 1; a_valid = t % 2 == 1; res_ready = 1;
            @(negedge clk);
            if (arr_in_valid) n_in++;
            exp_v = {in_rng(t,1,20), t == 20, in_rng(t,1,4), in_rng(t,1,4), in_rng(t,5,11),
                     in_rng(t,5,19), in_rng(t,5,11) && t % 2 == 1,
                     in_rng(t,12,18) && t % 2 == 0};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL bubbles t=%0d: got %b want %b", t, obs, exp_v);
            end
            if (t == 20) begin
                n_chk++;
                if (dut.sent_q !== 8'd4) begin
                    n_fail++;
                    $display("FAIL bubbles sent count: got %0d want 4", dut.sent_q);
                end
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (n_in != 4) begin
            n_fail++;
            $display("FAIL bubbles accepted: got %0d want 4", n_in);
        end
    endtask

    task automatic test_backpressure();
        int n_res = 0;
        for (int t = 0; t <= 22; t++) begin
            start = t == 0; num_vec = 8'd3;
            w_valid = 1; a_valid = 1; res_ready = !in_rng(t,10,14);
            @(negedge clk);
            if (res_valid) n_res++;
            exp_v = {in_rng(t,1,21), t == 21, in_rng(t,1,4), in_rng(t,1,4), in_rng(t,5,7),
                     in_rng(t,5,20) && !in_rng(t,10,14), in_rng(t,5,7), in_rng(t,17,19)};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL backpressure t=%0d: got %b want %b", t, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (n_res != 3) begin
            n_fail++;
            $display("FAIL backpressure results: got %0d want 3", n_res);
        end
    endtask

    task automatic test_zero_len();
        for (int t = 0; t <= 8; t++) begin
            start = t == 0; num_vec = 8'd0;
            w_valid = 1; a_valid = 1; res_ready = 1;
            @(negedge clk);
            exp_v = {in_rng(t,1,6), t == 6, in_rng(t,1,4), in_rng(t,1,4), 1'b0, t == 5, 1'b0, 1'b0};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL zero_len t=%0d: got %b want %b", t, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stream();
        int n_res = 0, n_in = 0, done_t = -1;
        for (int t = 0; t <= 6; t++) begin
            start = t == 0; num_vec = 8'd5;
            w_valid = 1; a_valid = 1; res_ready = 1;
            @(posedge clk); #1;
        end
        rst = 1;
        #1;
        n_chk++;
        if (obs !== 8'h00 || w_row !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset outputs: got %b row %0d, want 00000000 row 0", obs, w_row);
        end
        @(posedge clk); #1;
        rst = 0;
        for (int t = 0; t <= 18; t++) begin
            start = t == 0; num_vec = 8'd3;
            w_valid = 1; a_valid = 1; res_ready = 1;
            @(negedge clk);
            if (res_valid) n_res++;
            if (arr_in_valid) n_in++;
            if (done && done_t < 0) done_t = t;
            @(posedge clk); #1;
        end
        n_chk++;
        if (done_t != 16 || n_res != 3 || n_in != 3) begin
            n_fail++;
            $display("FAIL rerun: done at %0d res %0d in %0d, want done 16 res 3 in 3",
                     done_t, n_res, n_in);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        test_reset();
        test_basic();
        test_weight_stall();
        test_bubbles();
        test_backpressure();
        test_zero_len();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
